// File: rtl/taxi_axis_cobs_arb_if.sv
// AXI4-Stream bundle shared by the requester ports and the encoder-facing port.
//
// Handshake: a beat transfers on the rising clk edge where tvalid && tready
// are both high. A source holds tvalid and its payload stable until the beat
// transfers, and never derives tvalid from tready; a sink may raise or drop
// tready at any time.
interface taxi_axis_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = (DATA_W + 7) / 8,
  parameter int ID_W   = 1,
  parameter int DEST_W = 1,
  parameter int USER_W = 1
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [KEEP_W-1:0] tstrb;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [DEST_W-1:0] tdest;
  logic [USER_W-1:0] tuser;

  modport src (output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
               input  tready);
  modport snk (input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
               output tready);
  modport mon (input  tdata, tkeep, tstrb, tvalid, tready, tlast, tid, tdest, tuser);
endinterface

// File: rtl/taxi_axis_cobs_arb.sv
// Frame-atomic round-robin arbiter feeding one COBS encoder.
// Build option: define TAXI_AXIS_COBS_ARB_HDR_EN to prefix each frame with a
// one-byte channel header holding the granted port index.
// Frames longer than MAX_LEN payload bytes are cut at MAX_LEN (last byte marked
// tlast=1, tuser=1) and the remainder of the input frame is drained.
module taxi_axis_cobs_arb #(
  parameter int PORTS   = 4,
  parameter int MAX_LEN = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  taxi_axis_if.snk                 s_axis [PORTS],
  taxi_axis_if.src                 m_axis,
  output logic [$clog2(PORTS)-1:0] status_grant,
  output logic                     status_busy,
  output logic                     status_trunc
);

  localparam int GW = $clog2(PORTS);

  // ---------------------------------------------------------------------------
  // Elaboration guards
  // ---------------------------------------------------------------------------
  if (PORTS < 2 || PORTS > 8) begin : g_bad_ports
    $fatal(1, "taxi_axis_cobs_arb: PORTS must be 2..8");
  end
  if (MAX_LEN < 2 || MAX_LEN > 65535) begin : g_bad_len
    $fatal(1, "taxi_axis_cobs_arb: MAX_LEN must be 2..65535");
  end
  if ($bits(m_axis.tdata) != 8) begin : g_bad_m_width
    $fatal(1, "taxi_axis_cobs_arb: m_axis DATA_W must be 8");
  end

  // ---------------------------------------------------------------------------
  // Flatten the requester interface array
  // ---------------------------------------------------------------------------
  logic [PORTS-1:0] s_tvalid;
  logic [PORTS-1:0] s_tlast;
  logic [PORTS-1:0] s_tuser;
  logic [PORTS-1:0] s_tready;
  logic [7:0]       s_tdata [PORTS];

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    if ($bits(s_axis[i].tdata) != 8) begin : g_bad_s_width
      $fatal(1, "taxi_axis_cobs_arb: s_axis DATA_W must be 8");
    end
    assign s_tvalid[i]       = s_axis[i].tvalid;
    assign s_tlast[i]        = s_axis[i].tlast;
    assign s_tuser[i]        = s_axis[i].tuser[0];
    assign s_tdata[i]        = s_axis[i].tdata;
    assign s_axis[i].tready  = s_tready[i];
    // Sideband fields carry nothing for a byte stream and are ignored.
    logic unused_side;
    assign unused_side = ^{s_axis[i].tkeep, s_axis[i].tstrb,
                           s_axis[i].tid, s_axis[i].tdest};
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
`ifdef TAXI_AXIS_COBS_ARB_HDR_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PASS = 2'd2,
    ST_DROP = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd2,
    ST_DROP = 2'd3
  } state_t;
`endif

  state_t          state_q;
  state_t          state_d;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   rr_q;
  logic [15:0]     count_q;
  logic            trunc_q;

  // Arbitration candidate
  logic            cand_found;
  logic [GW-1:0]   cand_idx;
  logic [GW-1:0]   scan_idx;

  // Granted-port view
  logic            s_valid_g;
  logic            s_last_g;
  logic            s_user_g;
  logic [7:0]      s_data_g;
  logic            s_fire;
  logic            len_hit;

  // Beat offered to the skid buffer: {tuser, tlast, tdata}
  logic            int_valid;
  logic [9:0]      int_beat;
  logic            trunc_evt;
  logic            frame_end;

  // Skid buffer
  logic            int_ready_q;
  logic            int_ready_early;
  logic            out_valid_q;
  logic [9:0]      out_beat_q;
  logic            tmp_valid_q;
  logic [9:0]      tmp_beat_q;

  assign s_valid_g = s_tvalid[grant_q];
  assign s_last_g  = s_tlast[grant_q];
  assign s_user_g  = s_tuser[grant_q];
  assign s_data_g  = s_tdata[grant_q];
  assign s_fire    = (state_q == ST_PASS) && s_valid_g && int_ready_q;
  assign len_hit   = (count_q == 16'(MAX_LEN - 1));

  // Round-robin search: first valid port at or after rr_q, wrapping.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < PORTS; k++) begin
      scan_idx = GW'((int'(rr_q) + k) % PORTS);
      if (!cand_found && s_tvalid[scan_idx]) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: grant, optional header, payload, drain after truncation.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cand_found) begin
`ifdef TAXI_AXIS_COBS_ARB_HDR_EN
          state_d = ST_HDR;
`else
          state_d = ST_PASS;
`endif
        end
      end
`ifdef TAXI_AXIS_COBS_ARB_HDR_EN
      ST_HDR: begin
        if (int_ready_q) state_d = ST_PASS;
      end
`endif
      ST_PASS: begin
        if (s_fire) begin
          if (s_last_g)     state_d = ST_IDLE;
          else if (len_hit) state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (s_valid_g && s_last_g) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: requester tready, beat offered downstream, frame events.
  always_comb begin
    s_tready  = '0;
    int_valid = 1'b0;
    int_beat  = '0;
    trunc_evt = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
`ifdef TAXI_AXIS_COBS_ARB_HDR_EN
      ST_HDR: begin
        int_valid = int_ready_q;
        int_beat  = {2'b00, 8'(grant_q)};
      end
`endif
      ST_PASS: begin
        s_tready[grant_q] = int_ready_q;
        if (s_fire) begin
          int_valid = 1'b1;
          if (!s_last_g && len_hit) begin
            int_beat  = {1'b1, 1'b1, s_data_g};
            trunc_evt = 1'b1;
          end else begin
            int_beat  = {s_user_g && s_last_g, s_last_g, s_data_g};
            frame_end = s_last_g;
          end
        end
      end
      ST_DROP: begin
        s_tready[grant_q] = 1'b1;
        frame_end         = s_valid_g && s_last_g;
      end
      default: ;
    endcase
  end

  // Grant, round-robin pointer, payload counter and truncation pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      rr_q    <= '0;
      count_q <= '0;
      trunc_q <= 1'b0;
    end else begin
      trunc_q <= trunc_evt;
      if (state_q == ST_IDLE && cand_found) begin
        grant_q <= cand_idx;
        count_q <= '0;
      end else if (s_fire) begin
        count_q <= count_q + 16'd1;
      end
      if (frame_end) begin
        rr_q <= (grant_q == GW'(PORTS - 1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

  // Ready for the next cycle is registered so m_axis.tready never reaches
  // s_axis.tready combinationally; the temp slot absorbs the one beat that
  // may arrive while the output is stalled.
  assign int_ready_early = m_axis.tready ||
                           (!tmp_valid_q && (!out_valid_q || !int_valid));

  // Two-entry skid buffer (output register + temp register).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_beat_q  <= '0;
      tmp_valid_q <= 1'b0;
      tmp_beat_q  <= '0;
    end else begin
      int_ready_q <= int_ready_early;
      if (int_ready_q) begin
        if (m_axis.tready || !out_valid_q) begin
          out_valid_q <= int_valid;
          out_beat_q  <= int_beat;
        end else begin
          tmp_valid_q <= int_valid;
          tmp_beat_q  <= int_beat;
        end
      end else if (m_axis.tready) begin
        out_valid_q <= tmp_valid_q;
        out_beat_q  <= tmp_beat_q;
        tmp_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = out_valid_q;
  assign m_axis.tdata  = out_beat_q[7:0];
  assign m_axis.tlast  = out_beat_q[8];
  assign m_axis.tuser  = out_beat_q[9];
  assign m_axis.tkeep  = '1;
  assign m_axis.tstrb  = '1;
  assign m_axis.tid    = '0;
  assign m_axis.tdest  = '0;

  assign status_grant = grant_q;
  assign status_busy  = (state_q != ST_IDLE);
  assign status_trunc = trunc_q;

endmodule

// File: doc/taxi_axis_cobs_arb.md
TAXI_AXIS_COBS_ARB -- requirements
Module: taxi_axis_cobs_arb

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of byte-stream requesters sharing one downstream COBS encoder; legal range 2..8.
REQ-002 SHALL have parameter MAX_LEN, default 1024, maximum payload bytes per frame; legal range 2..65535.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_axis[PORTS], taxi_axis_if.snk, DATA_W 8, USER_W 1, requester streams.
REQ-006 SHALL have port m_axis, taxi_axis_if.src, DATA_W 8, USER_W 1, arbitrated stream to the encoder sink.
REQ-007 SHALL have port status_grant, output, $clog2(PORTS), index of the current or last granted port.
REQ-008 SHALL have port status_busy, output, 1, high while a frame is in progress.
REQ-009 SHALL have port status_trunc, output, 1, one-cycle pulse per truncated frame.

Function
REQ-010 SHALL stop elaboration with $fatal if any interface DATA_W is not 8 or PORTS is out of range.
REQ-011 SHALL implement states IDLE, HDR, PASS, DROP.
REQ-012 SHALL in IDLE grant round-robin: first port with tvalid at or after rr_ptr, wrapping PORTS-1 -> 0; no grant if none valid.
REQ-013 SHALL hold the grant for a whole frame; no switching before an accepted tlast (frame-atomic).
REQ-014 SHALL on grant go to HDR when the header feature is compiled in, otherwise to PASS.
REQ-015 SHALL assert s_axis[i].tready only in PASS or DROP for the granted i; all other tready low.
REQ-016 SHALL in PASS forward tdata and tlast unchanged, and set m_axis.tuser = s_axis.tuser && tlast.
REQ-017 SHALL count accepted payload bytes in a 16-bit counter cleared at grant; the header byte is not counted.
REQ-018 SHALL, on accepting byte MAX_LEN without tlast, emit it with tlast=1, tuser=1, pulse status_trunc, and enter DROP.
REQ-019 SHALL treat tlast on byte MAX_LEN as a normal, untruncated frame end.
REQ-020 SHALL in DROP accept and discard granted-port bytes until tlast, then go to IDLE.
REQ-021 SHALL on frame end (PASS or DROP tlast) set rr_ptr = grant+1 mod PORTS, go to IDLE, and clear status_busy.
REQ-022 SHALL register the output through a two-entry skid buffer: latency 1 cycle, full throughput, no combinational path from m_axis.tready to any s_axis.tready.
REQ-023 SHALL drive m_axis.tkeep=1, tstrb=1, tid=0, tdest=0.
REQ-024 SHALL allow a new grant in the IDLE cycle right after frame end, giving at most one idle bubble between frames.

Reset
REQ-025 SHALL on rst_n low immediately force: state IDLE, rr_ptr 0, counter 0, skid buffer empty, m_axis.tvalid 0, all s_axis tready 0, status_grant 0, status_busy 0, status_trunc 0.
REQ-026 SHALL discard a frame that was in flight at reset, with no tlast emitted; the downstream encoder is reset with the same rst_n.
REQ-027 SHALL not assert any tready or tvalid in the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL use macro TAXI_AXIS_COBS_ARB_HDR_EN to control the channel header.
REQ-029 SHALL, with the macro defined, emit in HDR one byte {zero-padded grant index} with tlast=0 before the payload, then go to PASS.
REQ-030 SHALL, with the macro undefined, remove the HDR state and emit payload only.

Verification
REQ-031 SHALL cover: ports 0 and 2 valid, rr_ptr 0, 3-byte frames -> port 0 frame, then port 2 frame, then rr_ptr=3.
REQ-032 SHALL cover: port 1 sends 01 00 02, port 3 valid mid-frame -> output 01 00 02 contiguous with no interleave, and port 3 granted after tlast.
REQ-033 SHALL cover: MAX_LEN=4, 6-byte frame -> 4 bytes out, 4th with tlast=1 and tuser=1, status_trunc pulses once, bytes 5-6 consumed and not output.
REQ-034 SHALL cover: MAX_LEN=4, 4-byte frame with tlast on byte 4 -> tuser=0, no status_trunc.
REQ-035 SHALL cover: HDR_EN defined, port 2 frame AA -> output 02, AA(tlast); HDR_EN undefined -> AA(tlast) only.
REQ-036 SHALL cover: m_axis.tready toggling 50% plus rst_n pulsed mid-frame -> no data lost or duplicated before reset, and all outputs at reset values within the reset cycle.
